// File: rtl/if_id_reg_pkg.sv
// Pipeline-wide definitions shared by the inter-stage registers of the 5-stage MIPS core.
// Holds the data width, the NOP encoding and the common stall/flush control decode.
package if_id_reg_pkg;

  localparam int DATA_W = 32;

  // sll $0,$0,0 encodes as all zeros; a flushed stage carries this as its bubble.
  localparam logic [DATA_W-1:0] NOP_INS = 32'h0000_0000;

  typedef struct packed {
    logic clear;
    logic load;
  } pipe_ctrl_t;

  // Freeze masks everything, and flush beats write. Reset is handled in the registers themselves.
  function automatic pipe_ctrl_t decode_ctrl(input logic clk_en,
                                             input logic flush,
                                             input logic write);
    pipe_ctrl_t ctrl;
    ctrl.clear = clk_en & flush;
    ctrl.load  = clk_en & ~flush & write;
    return ctrl;
  endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// IF -> ID stage bundle: the control and data that IF offers, and the registered view that ID sees.
// The master side is the IF stage and its control sources. The slave side is the IF/ID register.
interface if_id_reg_if
  import if_id_reg_pkg::*;
#(
  parameter int NB_REG = DATA_W
);

  logic              i_dunit_clk_en;
  logic              i_flush;
  logic              i_write;
  logic [NB_REG-1:0] i_pc_four;
  logic [NB_REG-1:0] i_data_ins_mem;
  logic [NB_REG-1:0] o_pc_four;
  logic [NB_REG-1:0] o_data_ins_mem;

  modport master (
    output i_dunit_clk_en, i_flush, i_write, i_pc_four, i_data_ins_mem,
    input  o_pc_four, o_data_ins_mem
  );

  modport slave (
    input  i_dunit_clk_en, i_flush, i_write, i_pc_four, i_data_ins_mem,
    output o_pc_four, o_data_ins_mem
  );

endinterface

// File: rtl/if_id_reg_pipe_reg.sv
// Generic NB-wide pipeline register with synchronous reset, synchronous clear, load and hold.
// It is used for each field of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
module pipe_reg #(
  parameter int          NB      = 32,
  parameter logic [NB-1:0] CLR_VAL = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic [NB-1:0] i_d,
  output logic [NB-1:0] o_q
);

  logic [NB-1:0] data_d;
  logic [NB-1:0] data_q;

  // NOTE: data_d defaults to data_q before any branch, so hold is explicit and no latch is inferred.
  always_comb begin
    data_d = data_q;
    if (i_clear) begin
      data_d = CLR_VAL;
    end else if (i_load) begin
      data_d = i_d;
    end
  end

  // NOTE: state updates use non-blocking assignment, so every stage samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_q <= CLR_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_q = data_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: latches PC+4 and the fetched instruction for the ID stage.
// It supports a hazard stall, a branch/jump flush to a NOP bubble, and a debug-unit freeze.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter int NB_REG = DATA_W
) (
  input logic          i_clk,
  input logic          i_reset,
  if_id_reg_if.slave   bus
);

  pipe_ctrl_t ctrl;

  always_comb begin
    ctrl = decode_ctrl(bus.i_dunit_clk_en, bus.i_flush, bus.i_write);
  end

  // Both fields share one control decode, so they can never update independently.
  pipe_reg #(
    .NB      (NB_REG),
    .CLR_VAL ('0)
  ) u_pc_four (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (ctrl.clear),
    .i_load  (ctrl.load),
    .i_d     (bus.i_pc_four),
    .o_q     (bus.o_pc_four)
  );

  pipe_reg #(
    .NB      (NB_REG),
    .CLR_VAL (NB_REG'(NOP_INS))
  ) u_ins (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (ctrl.clear),
    .i_load  (ctrl.load),
    .i_d     (bus.i_data_ins_mem),
    .o_q     (bus.o_data_ins_mem)
  );

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios followed by randomized control and data.
// A behavioural model applies the priority rules for reset, freeze, flush, write and hold.
module tb_if_id_reg;
  import if_id_reg_pkg::*;

  localparam int NB = 32;

  logic i_clk;
  logic i_reset;
  int   total;
  int   bad;

  logic [NB-1:0] exp_pc;
  logic [NB-1:0] exp_ins;

  if_id_reg_if #(.NB_REG(NB)) bus ();

  if_id_reg #(.NB_REG(NB)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: the register state after one rising edge, given the inputs present at that edge.
  task automatic model_edge(input logic rst, input logic en, input logic fl, input logic wr,
                            input logic [NB-1:0] pc, input logic [NB-1:0] ins);
    if (rst)       begin exp_pc = 0;  exp_ins = 0;   end
    else if (!en)  begin /* frozen */               end
    else if (fl)   begin exp_pc = 0;  exp_ins = 0;   end
    else if (wr)   begin exp_pc = pc; exp_ins = ins; end
  endtask

  // Apply the inputs, take one rising edge, and sample 1 time unit afterwards.
  task automatic step(input logic rst, input logic en, input logic fl, input logic wr,
                      input logic [NB-1:0] pc, input logic [NB-1:0] ins);
    i_reset            = rst;
    bus.i_dunit_clk_en = en;
    bus.i_flush        = fl;
    bus.i_write        = wr;
    bus.i_pc_four      = pc;
    bus.i_data_ins_mem = ins;
    @(posedge i_clk);
    model_edge(rst, en, fl, wr, pc, ins);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++;
    if (bus.o_pc_four !== 32'h0 || bus.o_data_ins_mem !== 32'h0) begin
      bad++;
      $display("FAIL reset: got %h/%h want 00000000/00000000", bus.o_pc_four, bus.o_data_ins_mem);
    end
  endtask

  task automatic test_write();
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    total++;
    if (bus.o_pc_four !== 32'hAAAA_AAAA || bus.o_data_ins_mem !== 32'hBBBB_BBBB) begin
      bad++;
      $display("FAIL write: got %h/%h want aaaaaaaa/bbbbbbbb", bus.o_pc_four, bus.o_data_ins_mem);
    end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hCCCC_CCCC, 32'hDDDD_DDDD);
    total++;
    if (bus.o_pc_four !== 32'hAAAA_AAAA || bus.o_data_ins_mem !== 32'hBBBB_BBBB) begin
      bad++;
      $display("FAIL stall: got %h/%h want aaaaaaaa/bbbbbbbb", bus.o_pc_four, bus.o_data_ins_mem);
    end
  endtask

  task automatic test_flush_stall();
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hCCCC_CCCC, 32'hDDDD_DDDD);
    total++;
    if (bus.o_pc_four !== 32'h0 || bus.o_data_ins_mem !== NOP_INS) begin
      bad++;
      $display("FAIL flush_stall: got %h/%h want 00000000/00000000", bus.o_pc_four, bus.o_data_ins_mem);
    end
  endtask

  task automatic test_resume();
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h8765_4321);
    total++;
    if (bus.o_pc_four !== 32'h1234_5678 || bus.o_data_ins_mem !== 32'h8765_4321) begin
      bad++;
      $display("FAIL resume: got %h/%h want 12345678/87654321", bus.o_pc_four, bus.o_data_ins_mem);
    end
  endtask

  task automatic test_freeze_priority();
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h8765_4321);
    // Frozen: flush and write are both ignored.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
    total++;
    if (bus.o_pc_four !== 32'h1234_5678 || bus.o_data_ins_mem !== 32'h8765_4321) begin
      bad++;
      $display("FAIL freeze: got %h/%h want 12345678/87654321", bus.o_pc_four, bus.o_data_ins_mem);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
    total++;
    if (bus.o_pc_four !== 32'h1234_5678 || bus.o_data_ins_mem !== 32'h8765_4321) begin
      bad++;
      $display("FAIL freeze_write: got %h/%h want 12345678/87654321", bus.o_pc_four, bus.o_data_ins_mem);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
    total++;
    if (bus.o_pc_four !== 32'h0 || bus.o_data_ins_mem !== 32'h0) begin
      bad++;
      $display("FAIL flush_beats_write: got %h/%h want 00000000/00000000", bus.o_pc_four, bus.o_data_ins_mem);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h5555_AAAA, 32'hAAAA_5555);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++;
    if (bus.o_pc_four !== 32'h0 || bus.o_data_ins_mem !== 32'h0) begin
      bad++;
      $display("FAIL reset_while_frozen: got %h/%h want 00000000/00000000", bus.o_pc_four, bus.o_data_ins_mem);
    end
  endtask

  task automatic test_first_capture();
    // With reset held, a write is ignored. The first capture follows deassertion.
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h2008_0001);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h2009_0002);
    total++;
    if (bus.o_pc_four !== 32'h0000_0008 || bus.o_data_ins_mem !== 32'h2009_0002) begin
      bad++;
      $display("FAIL first_capture: got %h/%h want 00000008/20090002", bus.o_pc_four, bus.o_data_ins_mem);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic rst, en, fl, wr;
      rst = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      wr  = ($urandom_range(0, 3) != 0);
      step(rst, en, fl, wr, $urandom(), $urandom());
      total++;
      if (bus.o_pc_four !== exp_pc || bus.o_data_ins_mem !== exp_ins) begin
        bad++;
        $display("FAIL random[%0d] r=%b e=%b f=%b w=%b: got %h/%h want %h/%h", n, rst, en, fl, wr,
                 bus.o_pc_four, bus.o_data_ins_mem, exp_pc, exp_ins);
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_pc  = 'x;
    exp_ins = 'x;
    test_reset();
    test_write();
    test_stall();
    test_flush_stall();
    test_resume();
    test_freeze_priority();
    test_first_capture();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
